// File: rtl/imultf_seq_pkg.sv
// imultf_seq shared types: default sizes, sequencer state codes
// and the packed request record layout {tag, sign, bits, b, a}.
package imultf_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_BITS_W    = 5;
  localparam int DEF_TAG_W     = 4;
  localparam int DEF_START_TMO = 3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WSTART = 3'd2;
  localparam logic [2:0] S_WDONE  = 3'd3;
  localparam logic [2:0] S_CAP    = 3'd4;

  // request record, msb..lsb: {tag, sign, bits, b, a}
  function automatic int req_w(int w, int bw, int tw);
    return tw + 1 + bw + 2 * w;
  endfunction

endpackage

// File: rtl/imultf_seq_if.sv
// Command and result valid/ready streams of imultf_seq.
// master = requester/consumer side, slave = sequencer side.
interface imultf_seq_if
  import imultf_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int BITS_W = DEF_BITS_W,
  parameter int TAG_W  = DEF_TAG_W
) ();

  logic                 req_valid;
  logic                 req_ready;
  logic [WIDTH-1:0]     req_a;
  logic [WIDTH-1:0]     req_b;
  logic [BITS_W-1:0]    req_bits;
  logic                 req_sign;
  logic [TAG_W-1:0]     req_tag;

  logic                 res_valid;
  logic                 res_ready;
  logic [2*WIDTH-1:0]   res_p;
  logic [TAG_W-1:0]     res_tag;

  modport master (
    output req_valid, req_a, req_b,
    output req_bits, req_sign, req_tag,
    input  req_ready,
    input  res_valid, res_p, res_tag,
    output res_ready
  );

  modport slave (
    input  req_valid, req_a, req_b,
    input  req_bits, req_sign, req_tag,
    output req_ready,
    output res_valid, res_p, res_tag,
    input  res_ready
  );

endinterface

// File: rtl/imultf_seq_sync_fifo2.sv
// sync_fifo2: two-entry register FIFO with count/full/empty.
// Ports: push/din in, pop/dout out (dout = head), async low reset.
module sync_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = count == 2'd2;
  assign empty   = count == 2'd0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push}
                     - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/imultf_seq.sv
// imultf_seq: buffers multiply commands, issues them one at a time
// to imultf (go/busy) and returns tagged products in request order.
module imultf_seq
  import imultf_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BITS_W    = DEF_BITS_W,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int START_TMO = DEF_START_TMO
) (
  input  logic               clk,
  input  logic               arstn,
  imultf_seq_if.slave        bus,
  output logic               mul_go,
  output logic               mul_sign,
  output logic [BITS_W-1:0]  mul_bits,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_busy,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic               inflight
);

  localparam int REQ_W = req_w(WIDTH, BITS_W, TAG_W);
  localparam int TMO_W = $clog2(START_TMO + 1);

  logic [REQ_W-1:0] fifo_din;
  logic [REQ_W-1:0] fifo_dout;
  logic [1:0]       fifo_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             res_free;
  logic [2:0]       state;
  logic [TAG_W-1:0] iss_tag;
  logic [TMO_W-1:0] tmo;

  assign bus.req_ready = fifo_cnt < 2'd2;
  assign push = bus.req_valid & ~fifo_full;
  assign fifo_din = {bus.req_tag, bus.req_sign,
                     bus.req_bits, bus.req_b, bus.req_a};

  // result slot is free if empty or being drained this cycle
  assign res_free = ~bus.res_valid | bus.res_ready;
  assign pop = (state == S_IDLE) & ~fifo_empty & res_free;

  assign mul_go   = state == S_ISSUE;
  assign inflight = state != S_IDLE;

  sync_fifo2 #(.W(REQ_W)) u_fifo (
    .clk   (clk),
    .rst_n (arstn),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state    <= S_IDLE;
      tmo      <= '0;
      iss_tag  <= '0;
      mul_sign <= 1'b0;
      mul_bits <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (pop) begin
          {iss_tag, mul_sign, mul_bits,
           mul_b, mul_a} <= fifo_dout;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          tmo   <= '0;
          state <= S_WSTART;
        end
        // tmo+1 cycles have passed since go; CAPTURE
        // lands START_TMO cycles after the go cycle
        S_WSTART: begin
          tmo <= tmo + 1'b1;
          if (mul_busy)
            state <= S_WDONE;
          else if (int'(tmo) + 2 >= START_TMO)
            state <= S_CAP;
        end
        S_WDONE: if (!mul_busy) state <= S_CAP;
        S_CAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      bus.res_valid <= 1'b0;
      bus.res_p     <= '0;
      bus.res_tag   <= '0;
    end else if (state == S_CAP) begin
      bus.res_valid <= 1'b1;
      bus.res_p     <= mul_p;
      bus.res_tag   <= iss_tag;
    end else if (bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imultf_seq.sv
// Bench for imultf_seq with a behavioural imultf(8) stand-in
// and a busy-never-rises stub mode.
module tb_imultf_seq;
  import imultf_pkg::*;

  localparam int TMO = DEF_START_TMO;

  logic        clk = 1'b0;
  logic        arstn;
  logic        mul_go;
  logic        mul_sign;
  logic [4:0]  mul_bits;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_busy;
  logic [15:0] mul_p;
  logic        inflight;
  logic        stub;

  int total = 0;
  int bad = 0;
  int go_cnt = 0;

  imultf_seq_if bus ();

  imultf_seq dut (
    .clk      (clk),
    .arstn    (arstn),
    .bus      (bus),
    .mul_go   (mul_go),
    .mul_sign (mul_sign),
    .mul_bits (mul_bits),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_busy (mul_busy),
    .mul_p    (mul_p),
    .inflight (inflight)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mul_go === 1'b1) go_cnt++;

  // imultf stand-in: busy for bits+1 cycles, product
  // appears when busy falls, computed from live operands
  logic        m_busy;
  int          m_cnt;
  logic [15:0] m_p;

  function automatic logic [15:0] mprod(
    input logic [7:0] a, input logic [7:0] b,
    input logic [4:0] bits, input logic s);
    logic [15:0] x;
    x = s ? {{8{a[7]}}, a} : {8'h00, a};
    x = x * {8'h00, b};
    return x << (7 - int'(bits));
  endfunction

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_p    <= 16'h0;
    end else if (mul_go) begin
      m_busy <= 1'b1;
      m_cnt  <= int'(mul_bits) + 1;
      m_p    <= 16'h0;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_p <= mprod(mul_a, mul_b, mul_bits, mul_sign);
      end
    end
  end

  assign mul_busy = stub ? 1'b0 : m_busy;
  assign mul_p    = stub ? 16'h1234 : m_p;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [7:0] a, input logic [7:0] b,
    input logic [4:0] bits, input logic s,
    input logic [3:0] tag, output bit ok);
    bus.req_a = a;
    bus.req_b = b;
    bus.req_bits = bits;
    bus.req_sign = s;
    bus.req_tag = tag;
    bus.req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready got=%b want=1", bus.req_ready);
    end
    total++;
    if (bus.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_res_valid got=%b want=0", bus.res_valid);
    end
    total++;
    if (mul_go !== 1'b0 || inflight !== 1'b0) begin
      bad++;
      $display("FAIL rst_go_inflight got=%b%b want=00",
               mul_go, inflight);
    end
    total++;
    if (bus.res_p !== 16'h0 || bus.res_tag !== 4'h0) begin
      bad++;
      $display("FAIL rst_res got=%h/%h want=0000/0",
               bus.res_p, bus.res_tag);
    end
    total++;
    if ({mul_a, mul_b, mul_bits, mul_sign} !== 22'h0) begin
      bad++;
      $display("FAIL rst_mul_ops got=%h %h %h %b want=0",
               mul_a, mul_b, mul_bits, mul_sign);
    end
    @(negedge clk);
    arstn = 1'b1;
    tick();
    tick();
    total++;
    if (inflight !== 1'b0 || go_cnt !== 0) begin
      bad++;
      $display("FAIL rst_idle got=%b/%0d want=0/0",
               inflight, go_cnt);
    end
  endtask

  task automatic test_single(
    input logic [7:0] a, input logic [7:0] b,
    input logic [4:0] bits, input logic s,
    input logic [3:0] tag, input logic [15:0] exp);
    int g0;
    int n;
    bit ok;
    g0 = go_cnt;
    send(a, b, bits, s, tag, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL single_accept tag=%0d got=0 want=1", tag);
    end
    total++;
    if (mul_go !== 1'b0) begin
      bad++;
      $display("FAIL single_go_early got=%b want=0", mul_go);
    end
    tick();
    total++;
    if (mul_go !== 1'b1) begin
      bad++;
      $display("FAIL single_go got=%b want=1", mul_go);
    end
    total++;
    if (mul_a !== a || mul_b !== b ||
        mul_bits !== bits || mul_sign !== s) begin
      bad++;
      $display("FAIL single_ops got=%h %h %h %b want=%h %h %h %b",
               mul_a, mul_b, mul_bits, mul_sign, a, b, bits, s);
    end
    tick();
    total++;
    if (mul_go !== 1'b0) begin
      bad++;
      $display("FAIL single_go_width got=%b want=0", mul_go);
    end
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (bus.res_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_timeout got=0 want=1 tag=%0d", tag);
    end
    total++;
    if (bus.res_p !== exp || bus.res_tag !== tag) begin
      bad++;
      $display("FAIL single_res got=%h/%0d want=%h/%0d",
               bus.res_p, bus.res_tag, exp, tag);
    end
    total++;
    if (go_cnt - g0 !== 1) begin
      bad++;
      $display("FAIL single_go_count got=%0d want=1", go_cnt - g0);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    total++;
    if (bus.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drain got=%b want=0", bus.res_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, ok3;
    int n;
    int k;
    logic [15:0] gp [3];
    logic [3:0]  gt [3];
    logic [15:0] ep [3];
    logic [3:0]  et [3];
    ep[0] = 16'h4284; ep[1] = 16'hAD5C; ep[2] = 16'hFE01;
    et[0] = 4'd1; et[1] = 4'd2; et[2] = 4'd3;
    send(8'd99, 8'd43, 5'd5, 1'b1, 4'd1, ok1);
    send(8'h85, 8'd43, 5'd5, 1'b1, 4'd2, ok2);
    send(8'd255, 8'd255, 5'd7, 1'b0, 4'd3, ok3);
    total++;
    if (!(ok1 && ok2 && ok3)) begin
      bad++;
      $display("FAIL b2b_accept got=%b%b%b want=111",
               ok1, ok2, ok3);
    end
    total++;
    if (bus.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_full got=%b want=0", bus.req_ready);
    end
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    repeat (20) tick();
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_p !== 16'h4284 ||
        bus.res_tag !== 4'd1) begin
      bad++;
      $display("FAIL b2b_hold got=%b %h/%0d want=1 4284/1",
               bus.res_valid, bus.res_p, bus.res_tag);
    end
    total++;
    if (bus.req_ready !== 1'b0 || inflight !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stall got=%b%b want=00",
               bus.req_ready, inflight);
    end
    bus.res_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 200 && k < 3; i++) begin
      if (bus.res_valid === 1'b1) begin
        gp[k] = bus.res_p;
        gt[k] = bus.res_tag;
        k++;
      end
      tick();
    end
    bus.res_ready = 1'b0;
    total++;
    if (k !== 3) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=3", k);
    end
    for (int i = 0; i < k; i++) begin
      total++;
      if (gp[i] !== ep[i] || gt[i] !== et[i]) begin
        bad++;
        $display("FAIL b2b_order%0d got=%h/%0d want=%h/%0d",
                 i, gp[i], gt[i], ep[i], et[i]);
      end
    end
    total++;
    if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got=%b%b want=10",
               bus.req_ready, bus.res_valid);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    stub = 1'b1;
    send(8'd10, 8'd20, 5'd5, 1'b0, 4'd5, ok);
    tick();
    total++;
    if (!ok || mul_go !== 1'b1) begin
      bad++;
      $display("FAIL tmo_go got=%b%b want=11", ok, mul_go);
    end
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n !== TMO + 1) begin
      bad++;
      $display("FAIL tmo_latency got=%0d want=%0d", n, TMO + 1);
    end
    total++;
    if (bus.res_p !== 16'h1234 || bus.res_tag !== 4'd5) begin
      bad++;
      $display("FAIL tmo_res got=%h/%0d want=1234/5",
               bus.res_p, bus.res_tag);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    stub = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2;
    int n;
    int g0;
    send(8'd99, 8'd43, 5'd5, 1'b1, 4'd6, ok1);
    send(8'd1, 8'd2, 5'd5, 1'b0, 4'd7, ok2);
    tick();
    tick();
    total++;
    if (!(ok1 && ok2) || inflight !== 1'b1 ||
        mul_busy !== 1'b1) begin
      bad++;
      $display("FAIL rmid_pre got=%b%b%b%b want=1111",
               ok1, ok2, inflight, mul_busy);
    end
    arstn = 1'b0;
    #1;
    total++;
    if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
        inflight !== 1'b0 || mul_go !== 1'b0) begin
      bad++;
      $display("FAIL rmid_async got=%b%b%b%b want=0100",
               bus.res_valid, bus.req_ready, inflight, mul_go);
    end
    total++;
    if (mul_a !== 8'h0 || mul_b !== 8'h0) begin
      bad++;
      $display("FAIL rmid_ops got=%h %h want=00 00", mul_a, mul_b);
    end
    g0 = go_cnt;
    repeat (3) tick();
    @(negedge clk);
    arstn = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (inflight !== 1'b0 || bus.res_valid !== 1'b0) n++;
    end
    total++;
    if (go_cnt !== g0 || n !== 0) begin
      bad++;
      $display("FAIL rmid_quiet got=%0d/%0d want=0/0",
               go_cnt - g0, n);
    end
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rmid_empty got=%b want=1", bus.req_ready);
    end
    test_single(8'h85, 8'd43, 5'd5, 1'b1, 4'd8, 16'hAD5C);
  endtask

  initial begin
    arstn = 1'b0;
    stub = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a = 8'h0;
    bus.req_b = 8'h0;
    bus.req_bits = 5'h0;
    bus.req_sign = 1'b0;
    bus.req_tag = 4'h0;
    bus.res_ready = 1'b0;
    repeat (3) tick();
    test_reset();
    test_single(8'd99, 8'd43, 5'd5, 1'b1, 4'd1, 16'h4284);
    test_single(8'h85, 8'd43, 5'd5, 1'b1, 4'd2, 16'hAD5C);
    test_single(8'd255, 8'd255, 5'd7, 1'b0, 4'd3, 16'hFE01);
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
